// File: rtl/sys_timer_pkg.sv
// Shared definitions for the interval-timer sequencer: register map, control
// bits, client command encodings and the sequencer state enum.
package sys_timer_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam logic [15:0] CTRL_WORD_STOP  = 16'h0001 << CTRL_STOP;
    localparam logic [15:0] CTRL_WORD_START = (16'h0001 << CTRL_ITO) | (16'h0001 << CTRL_START);

    typedef enum logic [1:0] {
        OP_START = 2'b00,
        OP_STOP  = 2'b01,
        OP_SNAP  = 2'b10,
        OP_RSVD  = 2'b11
    } cmd_op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RUN,
        ST_S_STOP,
        ST_S_PERL,
        ST_S_PERH,
        ST_S_CTRL,
        ST_S_CLR,
        ST_S_SNAP,
        ST_R_L,
        ST_R_H,
        ST_R_DONE,
        ST_S_IRQ
    } state_e;

    // The timer counts reload..0, so a period of N cycles needs reload N-1.
    function automatic logic [31:0] reload_value(input logic [31:0] period,
                                                 input int unsigned min_period);
        logic [31:0] eff;
        eff = (period < 32'(min_period)) ? 32'(min_period) : period;
        return eff - 32'd1;
    endfunction

endpackage

// File: rtl/sys_timer_bus_wr.sv
// Single-cycle Avalon-MM write driver: a strobe turns address/data into one
// write beat; without the strobe the address still passes through for reads.
module sys_timer_bus_wr (
    input  logic        wr_strobe_i,
    input  logic [2:0]  addr_i,
    input  logic [15:0] data_i,
    output logic [2:0]  tmr_address_o,
    output logic        tmr_chipselect_o,
    output logic        tmr_write_n_o,
    output logic [15:0] tmr_writedata_o
);

    assign tmr_address_o    = addr_i;
    assign tmr_chipselect_o = wr_strobe_i;
    assign tmr_write_n_o    = ~wr_strobe_i;
    assign tmr_writedata_o  = wr_strobe_i ? data_i : 16'h0000;

endmodule

// File: rtl/sys_timer_sequencer.sv
// Avalon-MM master that turns start/stop/snapshot commands into ordered timer
// register sequences and services the timer interrupt for a hardware client.
module sys_timer_sequencer
    import sys_timer_pkg::*;
#(
    parameter int unsigned MIN_PERIOD    = 2,
    parameter bit          CLEAR_ON_STOP = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [31:0] cmd_period_i,
    input  logic        cmd_continuous_i,
    output logic        timeout_pulse_o,
    output logic        snap_valid_o,
    output logic [31:0] snap_value_o,
    output logic        running_o,
    output logic        busy_o,
    output logic [2:0]  tmr_address_o,
    output logic        tmr_chipselect_o,
    output logic        tmr_write_n_o,
    output logic [15:0] tmr_writedata_o,
    input  logic [15:0] tmr_readdata_i,
    input  logic        tmr_irq_i
);

    state_e      state_q, state_d;
    cmd_op_e     op_q, op_d;
    logic [31:0] period_q, period_d;
    logic        cont_q, cont_d;
    logic        running_q, running_d;
    logic [15:0] snap_lo_q, snap_lo_d;
    logic [31:0] snap_value_q, snap_value_d;
    logic        timeout_pulse_q, timeout_pulse_d;

    logic        bus_wr;
    logic [2:0]  bus_addr;
    logic [15:0] bus_data;
    logic        idle_or_run;
    logic        cmd_accept;

    assign idle_or_run = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign cmd_ready_o = ~reset_i && idle_or_run && ~tmr_irq_i;
    assign cmd_accept  = cmd_valid_i && cmd_ready_o;

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        period_d        = period_q;
        cont_d          = cont_q;
        running_d       = running_q;
        snap_lo_d       = snap_lo_q;
        snap_value_d    = snap_value_q;
        timeout_pulse_d = 1'b0;
        bus_wr          = 1'b0;
        bus_addr        = REG_STATUS;
        bus_data        = 16'h0000;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                // A pending irq always wins over a new command.
                if (tmr_irq_i) begin
                    state_d = ST_S_IRQ;
                end else if (cmd_accept) begin
                    op_d = cmd_op_e'(cmd_op_i);
                    case (cmd_op_i)
                        OP_START: begin
                            period_d = reload_value(cmd_period_i, MIN_PERIOD);
                            cont_d   = cmd_continuous_i;
                            state_d  = ST_S_STOP;
                        end
                        OP_STOP: state_d = ST_S_STOP;
                        OP_SNAP: state_d = ST_S_SNAP;
                        OP_RSVD: state_d = state_q;
                    endcase
                end
            end
            ST_S_STOP: begin
                bus_wr   = 1'b1;
                bus_addr = REG_CONTROL;
                bus_data = CTRL_WORD_STOP;
                if (op_q == OP_START) begin
                    state_d = ST_S_PERL;
                end else if (CLEAR_ON_STOP) begin
                    state_d = ST_S_CLR;
                end else begin
                    state_d   = ST_IDLE;
                    running_d = 1'b0;
                end
            end
            ST_S_PERL: begin
                bus_wr   = 1'b1;
                bus_addr = REG_PERIOD_L;
                bus_data = period_q[15:0];
                state_d  = ST_S_PERH;
            end
            ST_S_PERH: begin
                bus_wr   = 1'b1;
                bus_addr = REG_PERIOD_H;
                bus_data = period_q[31:16];
                state_d  = ST_S_CTRL;
            end
            ST_S_CTRL: begin
                bus_wr    = 1'b1;
                bus_addr  = REG_CONTROL;
                bus_data  = CTRL_WORD_START | (16'(cont_q) << CTRL_CONT);
                state_d   = ST_RUN;
                running_d = 1'b1;
            end
            ST_S_CLR: begin
                bus_wr    = 1'b1;
                bus_addr  = REG_STATUS;
                state_d   = ST_IDLE;
                running_d = 1'b0;
            end
            ST_S_SNAP: begin
                bus_wr   = 1'b1;
                bus_addr = REG_SNAP_L;
                state_d  = ST_R_L;
            end
            // Read data is registered in the timer, so each half arrives one
            // cycle after its address was presented.
            ST_R_L: begin
                bus_addr = REG_SNAP_L;
                state_d  = ST_R_H;
            end
            ST_R_H: begin
                bus_addr  = REG_SNAP_H;
                snap_lo_d = tmr_readdata_i;
                state_d   = ST_R_DONE;
            end
            ST_R_DONE: begin
                snap_value_d = {tmr_readdata_i, snap_lo_q};
                state_d      = running_q ? ST_RUN : ST_IDLE;
            end
            ST_S_IRQ: begin
                bus_wr          = 1'b1;
                bus_addr        = REG_STATUS;
                timeout_pulse_d = 1'b1;
                if (running_q && cont_q) begin
                    state_d = ST_RUN;
                end else begin
                    state_d   = ST_IDLE;
                    running_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= ST_IDLE;
            op_q            <= OP_START;
            period_q        <= '0;
            cont_q          <= 1'b0;
            running_q       <= 1'b0;
            snap_lo_q       <= '0;
            snap_value_q    <= '0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            period_q        <= period_d;
            cont_q          <= cont_d;
            running_q       <= running_d;
            snap_lo_q       <= snap_lo_d;
            snap_value_q    <= snap_value_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign timeout_pulse_o = timeout_pulse_q;
    assign snap_valid_o    = (state_q == ST_R_DONE);
    assign snap_value_o    = (state_q == ST_R_DONE) ? {tmr_readdata_i, snap_lo_q} : snap_value_q;
    assign running_o       = running_q;
    assign busy_o          = ~idle_or_run;

    sys_timer_bus_wr u_bus_wr (
        .wr_strobe_i      (bus_wr),
        .addr_i           (bus_addr),
        .data_i           (bus_data),
        .tmr_address_o    (tmr_address_o),
        .tmr_chipselect_o (tmr_chipselect_o),
        .tmr_write_n_o    (tmr_write_n_o),
        .tmr_writedata_o  (tmr_writedata_o)
    );

endmodule

// File: tb/tb_sys_timer_sequencer.sv
// Bench for sys_timer_sequencer: drives client commands against a behavioural
// interval-timer slave and compares bus traffic and client outputs to a model.
module tb_sys_timer_sequencer;

    localparam int MIN_PERIOD = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_period;
    logic        cmd_continuous;
    logic        timeout_pulse;
    logic        snap_valid;
    logic [31:0] snap_value;
    logic        running;
    logic        busy;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;

    int compared = 0;
    int failed   = 0;
    int cycle    = 0;

    always #5 clk = ~clk;

    sys_timer_sequencer #(.MIN_PERIOD(MIN_PERIOD), .CLEAR_ON_STOP(1'b1)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_op_i         (cmd_op),
        .cmd_period_i     (cmd_period),
        .cmd_continuous_i (cmd_continuous),
        .timeout_pulse_o  (timeout_pulse),
        .snap_valid_o     (snap_valid),
        .snap_value_o     (snap_value),
        .running_o        (running),
        .busy_o           (busy),
        .tmr_address_o    (tmr_address),
        .tmr_chipselect_o (tmr_chipselect),
        .tmr_write_n_o    (tmr_write_n),
        .tmr_writedata_o  (tmr_writedata),
        .tmr_readdata_i   (tmr_readdata),
        .tmr_irq_i        (tmr_irq)
    );

    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural interval timer: counts reload..0, flags timeout at zero.
    logic [15:0] tPerL, tPerH;
    logic        tIto, tCont, tRun, tTo;
    logic [31:0] tCnt, tSnap;
    logic        tWrite, tStartNow;

    assign tWrite    = (tmr_chipselect === 1'b1) && (tmr_write_n === 1'b0);
    assign tStartNow = tWrite && (tmr_address == 3'd1) && tmr_writedata[2];
    assign tmr_irq   = tTo & tIto;

    always @(posedge clk) begin
        if (reset) begin
            tPerL <= '0; tPerH <= '0; tIto <= 1'b0; tCont <= 1'b0;
            tRun <= 1'b0; tTo <= 1'b0; tCnt <= '0; tSnap <= '0; tmr_readdata <= '0;
        end else begin
            if (tRun && !tStartNow) begin
                if (tCnt == 0) begin
                    tTo <= 1'b1;
                    if (tCont) tCnt <= {tPerH, tPerL};
                    else       tRun <= 1'b0;
                end else begin
                    tCnt <= tCnt - 1;
                end
            end
            if (tWrite) begin
                case (tmr_address)
                    3'd0: tTo <= 1'b0;
                    3'd1: begin
                        tIto  <= tmr_writedata[0];
                        tCont <= tmr_writedata[1];
                        if (tmr_writedata[3]) tRun <= 1'b0;
                        if (tmr_writedata[2]) begin
                            tRun <= 1'b1;
                            tCnt <= {tPerH, tPerL};
                        end
                    end
                    3'd2: tPerL <= tmr_writedata;
                    3'd3: tPerH <= tmr_writedata;
                    3'd4, 3'd5: tSnap <= tCnt;
                    default: ;
                endcase
            end
            case (tmr_address)
                3'd0:    tmr_readdata <= {15'd0, tTo};
                3'd1:    tmr_readdata <= {12'd0, 1'b0, 1'b0, tCont, tIto};
                3'd2:    tmr_readdata <= tPerL;
                3'd3:    tmr_readdata <= tPerH;
                3'd4:    tmr_readdata <= tSnap[15:0];
                3'd5:    tmr_readdata <= tSnap[31:16];
                default: tmr_readdata <= 16'h0000;
            endcase
        end
    end

    typedef struct {
        int          cyc;
        logic [2:0]  addr;
        logic [15:0] data;
        bit          chk;
    } wr_t;

    wr_t         wrQ[$];
    wr_t         expQ[$];
    int          pulseQ[$];
    int          snapCyc[$];
    logic [31:0] snapVal[$];

    always @(negedge clk) begin
        if (tWrite) wrQ.push_back('{cycle, tmr_address, tmr_writedata, 1'b1});
        if (timeout_pulse === 1'b1) pulseQ.push_back(cycle);
        if (snap_valid === 1'b1) begin
            snapCyc.push_back(cycle);
            snapVal.push_back(snap_value);
        end
    end

    task automatic stepCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic clearQueues();
        wrQ.delete();
        pulseQ.delete();
        snapCyc.delete();
        snapVal.delete();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkRange(input string tag, input int obs, input int lo, input int hi);
        compared++;
        assert (obs >= lo && obs <= hi) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Expected register writes for one client command.
    task automatic buildExpected(input logic [1:0] op, input logic [31:0] period, input logic cont);
        logic [31:0] eff, reload;
        expQ.delete();
        eff    = (period < MIN_PERIOD) ? 32'(MIN_PERIOD) : period;
        reload = eff - 1;
        case (op)
            2'b00: begin
                expQ.push_back('{0, 3'd1, 16'h0008, 1'b1});
                expQ.push_back('{0, 3'd2, reload[15:0], 1'b1});
                expQ.push_back('{0, 3'd3, reload[31:16], 1'b1});
                expQ.push_back('{0, 3'd1, cont ? 16'h0007 : 16'h0005, 1'b1});
            end
            2'b01: begin
                expQ.push_back('{0, 3'd1, 16'h0008, 1'b1});
                expQ.push_back('{0, 3'd0, 16'h0000, 1'b1});
            end
            2'b10: expQ.push_back('{0, 3'd4, 16'h0000, 1'b0});
            default: ;
        endcase
    endtask

    task automatic checkWrites(input string tag, input int firstCyc);
        checkOutput({tag, "_count"}, wrQ.size(), expQ.size());
        for (int i = 0; i < wrQ.size() && i < expQ.size(); i++) begin
            checkOutput({tag, "_addr"}, 32'(wrQ[i].addr), 32'(expQ[i].addr));
            if (expQ[i].chk) checkOutput({tag, "_data"}, 32'(wrQ[i].data), 32'(expQ[i].data));
            checkOutput({tag, "_cycle"}, wrQ[i].cyc, firstCyc + i);
        end
    endtask

    // Holds the command until the handshake completes; returns the cycle
    // number just before the accepting edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] period,
                                 input logic cont, output int acceptCycle);
        int n;
        cmd_valid      = 1'b1;
        cmd_op         = op;
        cmd_period     = period;
        cmd_continuous = cont;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            stepCycle();
            n++;
        end
        if (cmd_ready !== 1'b1) checkOutput("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        acceptCycle = cycle;
        stepCycle();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int acc, irqCyc, n;
        logic [31:0] per;
        logic        cont;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_period = '0; cmd_continuous = 1'b0;
        repeat (3) stepCycle();
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 0);
        checkOutput("rst_chipselect", 32'(tmr_chipselect), 0);
        checkOutput("rst_write_n", 32'(tmr_write_n), 1);
        checkOutput("rst_address", 32'(tmr_address), 0);
        checkOutput("rst_writedata", 32'(tmr_writedata), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_running", 32'(running), 0);
        checkOutput("rst_timeout", 32'(timeout_pulse), 0);
        checkOutput("rst_snap_valid", 32'(snap_valid), 0);
        checkOutput("rst_snap_value", snap_value, 0);
        reset = 1'b0;
        stepCycle();
        checkOutput("ready_after_reset", 32'(cmd_ready), 1);

        clearQueues();
        applyStimulus(2'b00, 32'd50000, 1'b1, acc);
        repeat (6) stepCycle();
        buildExpected(2'b00, 32'd50000, 1'b1);
        checkWrites("start50k", acc + 1);
        checkOutput("running_50k", 32'(running), 1);
        checkOutput("busy_50k", 32'(busy), 0);

        clearQueues();
        applyStimulus(2'b01, 32'd0, 1'b0, acc);
        repeat (4) stepCycle();
        buildExpected(2'b01, 32'd0, 1'b0);
        checkWrites("stop50k", acc + 1);
        checkOutput("running_stop", 32'(running), 0);
        checkOutput("no_pulse_50k", pulseQ.size(), 0);

        // One-shot and clamped one-shot each give exactly one serviced timeout.
        for (int k = 0; k < 2; k++) begin
            per = (k == 0) ? 32'd10 : 32'd1;
            clearQueues();
            applyStimulus(2'b00, per, 1'b0, acc);
            repeat (6) stepCycle();
            buildExpected(2'b00, per, 1'b0);
            checkWrites(k == 0 ? "oneshot10" : "clamp1", acc + 1);
            wrQ.delete();
            repeat (40) stepCycle();
            checkOutput("oneshot_pulses", pulseQ.size(), 1);
            checkOutput("oneshot_irq_writes", wrQ.size(), 1);
            if (wrQ.size() == 1 && pulseQ.size() == 1) begin
                checkOutput("oneshot_irq_addr", 32'(wrQ[0].addr), 0);
                checkOutput("oneshot_pulse_cycle", pulseQ[0], wrQ[0].cyc + 1);
            end
            checkOutput("oneshot_running", 32'(running), 0);
            checkOutput("oneshot_busy", 32'(busy), 0);
        end

        for (int it = 0; it < 6; it++) begin
            per  = $urandom_range(50, 70000);
            cont = 1'($urandom_range(0, 1));
            clearQueues();
            applyStimulus(2'b00, per, cont, acc);
            repeat (6) stepCycle();
            buildExpected(2'b00, per, cont);
            checkWrites("rnd_start", acc + 1);
            checkOutput("rnd_running", 32'(running), 1);

            clearQueues();
            applyStimulus(2'b10, 32'd0, 1'b0, acc);
            repeat (6) stepCycle();
            buildExpected(2'b10, 32'd0, 1'b0);
            checkWrites("rnd_snap_wr", acc + 1);
            checkOutput("snap_strobes", snapCyc.size(), 1);
            if (snapCyc.size() == 1) begin
                checkOutput("snap_latency", snapCyc[0], acc + 4);
                checkOutput("snap_value", snapVal[0], tSnap);
                checkRange("snap_below_period", int'(snapVal[0]), 0, int'(per) - 1);
            end
            checkOutput("snap_hold", snap_value, tSnap);
            checkOutput("snap_running", 32'(running), 1);

            clearQueues();
            applyStimulus(2'b11, 32'd0, 1'b0, acc);
            repeat (4) stepCycle();
            checkOutput("rsvd_writes", wrQ.size(), 0);
            checkOutput("rsvd_busy", 32'(busy), 0);

            clearQueues();
            applyStimulus(2'b01, 32'd0, 1'b0, acc);
            repeat (4) stepCycle();
            buildExpected(2'b01, 32'd0, 1'b0);
            checkWrites("rnd_stop", acc + 1);
            checkOutput("rnd_stopped", 32'(running), 0);
        end

        per = $urandom_range(100, 400);
        clearQueues();
        applyStimulus(2'b00, per, 1'b1, acc);
        n = 0;
        while (pulseQ.size() < 3 && n < int'(per) * 4 + 100) begin
            stepCycle();
            n++;
        end
        checkRange("cont_pulse_count", pulseQ.size(), 3, 1000);
        for (int i = 1; i < pulseQ.size() && i < 3; i++)
            checkRange("cont_interval", pulseQ[i] - pulseQ[i-1], int'(per) - 2, int'(per) + 2);
        checkOutput("cont_running", 32'(running), 1);

        // Stop request arrives in the very cycle the irq rises.
        n = 0;
        while (tmr_irq === 1'b1 && n < 10) begin stepCycle(); n++; end
        n = 0;
        while (tmr_irq !== 1'b1 && n < int'(per) + 50) begin stepCycle(); n++; end
        checkOutput("irq_seen", 32'(tmr_irq), 1);
        irqCyc = cycle;
        clearQueues();
        applyStimulus(2'b01, 32'd0, 1'b0, acc);
        repeat (6) stepCycle();
        checkOutput("coll_accept_cycle", acc, irqCyc + 2);
        expQ.delete();
        expQ.push_back('{0, 3'd0, 16'h0000, 1'b1});
        checkOutput("coll_first_addr", wrQ.size() > 0 ? 32'(wrQ[0].addr) : 32'hFFFF, 0);
        checkOutput("coll_first_cycle", wrQ.size() > 0 ? wrQ[0].cyc : -1, irqCyc + 1);
        if (wrQ.size() > 0) void'(wrQ.pop_front());
        buildExpected(2'b01, 32'd0, 1'b0);
        checkWrites("coll_stop", irqCyc + 3);
        repeat (int'(per) + 20) stepCycle();
        checkOutput("coll_pulses", pulseQ.size(), 1);
        if (pulseQ.size() > 0) checkOutput("coll_pulse_cycle", pulseQ[0], irqCyc + 2);
        checkOutput("coll_running", 32'(running), 0);

        clearQueues();
        applyStimulus(2'b01, 32'd0, 1'b0, acc);
        repeat (4) stepCycle();
        buildExpected(2'b01, 32'd0, 1'b0);
        checkWrites("stop_idle", acc + 1);

        clearQueues();
        applyStimulus(2'b00, 32'd500, 1'b1, acc);
        stepCycle();
        checkOutput("in_perl_addr", 32'(tmr_address), 2);
        reset = 1'b1;
        stepCycle();
        checkOutput("midrst_chipselect", 32'(tmr_chipselect), 0);
        checkOutput("midrst_write_n", 32'(tmr_write_n), 1);
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_ready", 32'(cmd_ready), 0);
        checkOutput("midrst_running", 32'(running), 0);
        reset = 1'b0;
        stepCycle();
        checkOutput("midrst_ready_after", 32'(cmd_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
